vertex_task_scheduler: RTL and testbench

Sequences dispatch of up to 64 pending work items (active vertices or PE tasks) to one downstream consumer. It holds a 64-bit pending bitmap and picks the next index with a priority search. It issues that index over a valid/ready handshake and clears the served bit. It signals completion when the bitmap drains. It sits between the activation logic that produces vertex masks and the PE dispatch port.

---
 rtl/vertex_task_scheduler_if.sv | 21 ++
 rtl/vertex_task_scheduler.sv | 117 +++++++++++
 tb/tb_vertex_task_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vertex_task_scheduler_if.sv
// Grant handshake between the vertex task scheduler and the PE dispatch port.
// The scheduler drives grant_valid/grant_idx and the consumer answers with grant_ready.
interface vertex_task_scheduler_if #(
    parameter int IDX_W = 6
);
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_ready;

    modport master (
        output grant_valid,
        output grant_idx,
        input  grant_ready
    );

    modport slave (
        input  grant_valid,
        input  grant_idx,
        output grant_ready
    );
endinterface

// File: rtl/vertex_task_scheduler.sv
// Drains a 64-bit pending bitmap one index at a time over a valid/ready grant port.
// Define ROUND_ROBIN_EN for round-robin search; the default build uses fixed lowest-index priority.
module vertex_task_scheduler #(
    parameter int N_REQ = 64,
    parameter int IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_REQ-1:0]       start_mask,
    input  logic                   add_valid,
    input  logic [N_REQ-1:0]       add_mask,
    vertex_task_scheduler_if.master gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W:0]         grant_count
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE
    } state_t;

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [IDX_W-1:0] last;

    logic [N_REQ-1:0] add_bits;
    logic [N_REQ-1:0] eff;
    logic [N_REQ-1:0] clear_mask;
    logic [IDX_W-1:0] pick;

    // Candidate set and the index the search would choose this cycle.
    always_comb begin
        add_bits   = add_valid ? add_mask : '0;
        eff        = pending | add_bits;
        clear_mask = {{(N_REQ-1){1'b0}}, 1'b1} << gnt.grant_idx;
        pick       = '0;
`ifdef ROUND_ROBIN_EN
        // Walk downward so the first set bit at or after last+1 is the one left in pick.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eff[last + IDX_W'(i) + IDX_W'(1)]) begin
                pick = last + IDX_W'(i) + IDX_W'(1);
            end
        end
`else
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eff[i]) begin
                pick = IDX_W'(i);
            end
        end
`endif
    end

`ifndef ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= '0;
            last            <= '1;
            gnt.grant_valid <= 1'b0;
            gnt.grant_idx   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            grant_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pending     <= start_mask;
                        grant_count <= '0;
                        last        <= '1;
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (eff == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        gnt.grant_idx   <= pick;
                        gnt.grant_valid <= 1'b1;
                        pending         <= eff;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gnt.grant_valid && gnt.grant_ready) begin
                        // The add is applied after the clear so a colliding add keeps its bit.
                        pending         <= (pending & ~clear_mask) | add_bits;
                        grant_count     <= grant_count + {{IDX_W{1'b0}}, 1'b1};
                        last            <= gnt.grant_idx;
                        gnt.grant_valid <= 1'b0;
                        state           <= SELECT;
                    end else begin
                        pending <= eff;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_task_scheduler.sv
// Directed self-checking bench for vertex_task_scheduler; cycle numbers count from the edge sampling start.
// Priority-order expectations follow ROUND_ROBIN_EN when it is defined.
module tb_vertex_task_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] start_mask;
    logic        add_valid;
    logic [63:0] add_mask;
    logic        busy;
    logic        done;
    logic [6:0]  grant_count;

    int total;
    int bad;

    vertex_task_scheduler_if #(.IDX_W(6)) gnt_if ();

    vertex_task_scheduler #(.N_REQ(64), .IDX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_mask (start_mask),
        .add_valid  (add_valid),
        .add_mask   (add_mask),
        .gnt        (gnt_if),
        .busy       (busy),
        .done       (done),
        .grant_count(grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; outputs then belong to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Batch with three grants at cycles 2, 4, 6, optionally adding items during the first handshake.
    task automatic applyStimulus(input string tag, input logic [63:0] mask, input logic [63:0] extra,
                                 input logic [5:0] g0, input logic [5:0] g1, input logic [5:0] g2);
        logic [5:0] exp_idx;
        start               = 1'b1;
        start_mask          = mask;
        gnt_if.grant_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            add_valid = 1'b0;
            add_mask  = '0;
            checkOutput({tag, "_valid"}, 64'(gnt_if.grant_valid), 64'(c == 2 || c == 4 || c == 6));
            checkOutput({tag, "_done"}, 64'(done), 64'(c == 8));
            checkOutput({tag, "_busy"}, 64'(busy), 64'(c <= 8));
            if (gnt_if.grant_valid) begin
                exp_idx = (c == 2) ? g0 : (c == 4) ? g1 : g2;
                checkOutput({tag, "_idx"}, 64'(gnt_if.grant_idx), 64'(exp_idx));
            end
            if (c == 2 && extra != '0) begin
                add_valid = 1'b1;
                add_mask  = extra;
            end
        end
        checkOutput({tag, "_count"}, 64'(grant_count), 64'd3);
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst                = 1'b1;
        start              = 1'b0;
        start_mask         = '0;
        add_valid          = 1'b0;
        add_mask           = '0;
        gnt_if.grant_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", 64'(gnt_if.grant_valid), 64'd0);
        checkOutput("rst_idx", 64'(gnt_if.grant_idx), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_count", 64'(grant_count), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] empty batch");
        start      = 1'b1;
        start_mask = '0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checkOutput("empty_valid", 64'(gnt_if.grant_valid), 64'd0);
            checkOutput("empty_done", 64'(done), 64'(c == 2));
            checkOutput("empty_busy", 64'(busy), 64'(c <= 2));
        end
        checkOutput("empty_count", 64'(grant_count), 64'd0);

        $display("[TB] basic drain");
        applyStimulus("drain", (64'd1 << 63) | (64'd1 << 3) | 64'd1, 64'd0, 6'd0, 6'd3, 6'd63);

        $display("[TB] backpressure");
        gnt_if.grant_ready = 1'b0;
        start              = 1'b1;
        start_mask         = 64'd1 << 7;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            checkOutput("bp_valid", 64'(gnt_if.grant_valid), 64'd1);
            checkOutput("bp_idx", 64'(gnt_if.grant_idx), 64'd7);
            if (c == 7) gnt_if.grant_ready = 1'b1;
        end
        tick();
        checkOutput("bp_valid_after", 64'(gnt_if.grant_valid), 64'd0);
        tick();
        checkOutput("bp_done", 64'(done), 64'd1);
        tick();
        checkOutput("bp_count", 64'(grant_count), 64'd1);
        checkOutput("bp_busy", 64'(busy), 64'd0);

        $display("[TB] add/clear collision");
        applyStimulus("collide", 64'd1 << 5, (64'd1 << 5) | (64'd1 << 2), 6'd5, 6'd2, 6'd5);

        $display("[TB] priority order");
`ifdef ROUND_ROBIN_EN
        applyStimulus("prio", (64'd1 << 1) | (64'd1 << 10), 64'd1, 6'd1, 6'd10, 6'd0);
`else
        applyStimulus("prio", (64'd1 << 1) | (64'd1 << 10), 64'd1, 6'd1, 6'd0, 6'd10);
`endif

        $display("[TB] reset mid-issue");
        gnt_if.grant_ready = 1'b0;
        start              = 1'b1;
        start_mask         = 64'd1 << 9;
        tick();
        start = 1'b0;
        tick();
        checkOutput("mid_valid_pre", 64'(gnt_if.grant_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_valid", 64'(gnt_if.grant_valid), 64'd0);
        checkOutput("mid_idx", 64'(gnt_if.grant_idx), 64'd0);
        checkOutput("mid_busy", 64'(busy), 64'd0);
        checkOutput("mid_count", 64'(grant_count), 64'd0);
        tick();
        checkOutput("mid_done", 64'(done), 64'd0);
        rst                = 1'b0;
        gnt_if.grant_ready = 1'b1;
        start              = 1'b1;
        start_mask         = 64'd1 << 4;
        tick();
        start = 1'b0;
        checkOutput("post_valid_c1", 64'(gnt_if.grant_valid), 64'd0);
        tick();
        checkOutput("post_valid_c2", 64'(gnt_if.grant_valid), 64'd1);
        checkOutput("post_idx", 64'(gnt_if.grant_idx), 64'd4);
        tick();
        tick();
        checkOutput("post_done", 64'(done), 64'd1);
        tick();
        checkOutput("post_count", 64'(grant_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
